i2c_cmd_queue: RTL and testbench

// - Upstream feeder for the I2C master FSM (next_idle/next_* state logic). Buffers host

---
 rtl/i2c_cmd_queue_if.sv | 37 +++
 rtl/i2c_cmd_queue.sv | 129 ++++++++++++
 tb/tb_i2c_cmd_queue.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cmd_queue_if.sv
// Host-side and master-side handshake bundle for i2c_cmd_queue.
// The err_seq signal exists only when I2C_CMDQ_SEQ_CHECK_EN is defined.
interface i2c_cmd_queue_if #(
  parameter int AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_cmd;
  logic [7:0]    in_data;
  logic [2:0]    cmd_out;
  logic [7:0]    din_out;
  logic          write_out;
  logic          ready_in;
  logic [AW:0]   level;
  logic          busy;
  logic          err_timeout;
  logic          err_clr;
`ifdef I2C_CMDQ_SEQ_CHECK_EN
  logic          err_seq;
`endif

  modport slave (
    input  in_valid, in_cmd, in_data, ready_in, err_clr,
    output in_ready, cmd_out, din_out, write_out, level, busy, err_timeout
`ifdef I2C_CMDQ_SEQ_CHECK_EN
    , output err_seq
`endif
  );

  modport master (
    output in_valid, in_cmd, in_data, ready_in, err_clr,
    input  in_ready, cmd_out, din_out, write_out, level, busy, err_timeout
`ifdef I2C_CMDQ_SEQ_CHECK_EN
    , input err_seq
`endif
  );
endinterface

// File: rtl/i2c_cmd_queue.sv
// Command FIFO feeding an I2C master one command at a time over write/cmd/ready.
// Optional START/STOP sequence checking is enabled with `I2C_CMDQ_SEQ_CHECK_EN.
module i2c_cmd_queue #(
  parameter int          DEPTH   = 8,
  parameter int          AW      = 3,
  parameter logic [15:0] TIMEOUT = 16'd1023
) (
  input  logic           clk,
  input  logic           reset_n,
  i2c_cmd_queue_if.slave bus
);

  // Command encodings mirror include/i2c.vh.
  localparam logic [2:0] k_START_CMD   = 3'd1;
  localparam logic [2:0] k_WRITE_CMD   = 3'd2;
  localparam logic [2:0] k_READ_CMD    = 3'd3;
  localparam logic [2:0] k_STOP_CMD    = 3'd4;
  localparam logic [2:0] k_RESTART_CMD = 3'd5;
  localparam logic [AW:0] FULL_LVL     = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t        state;
  logic [2:0]    mem_cmd  [DEPTH];
  logic [7:0]    mem_data [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic [15:0]   ctr;
  logic          full, push, pop, legal, timeout_hit;
  logic [2:0]    head_cmd;
  logic [7:0]    head_data;

  assign full        = (count == FULL_LVL);
  assign push        = bus.in_valid && !full;
  assign pop         = (state == ISSUE);
  assign head_cmd    = mem_cmd[head];
  assign head_data   = mem_data[head];
  assign timeout_hit = (state == WAIT_ACK) && bus.ready_in && (ctr == TIMEOUT - 16'd1);

  assign bus.in_ready = !full;
  assign bus.level    = count;
  assign bus.busy     = (state != IDLE);

`ifdef I2C_CMDQ_SEQ_CHECK_EN
  logic bus_held;
  // bus_held only changes in ISSUE, so legality seen in IDLE still holds in ISSUE
  assign legal = (head_cmd == k_START_CMD) ? !bus_held : bus_held;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus_held    <= 1'b0;
      bus.err_seq <= 1'b0;
    end else begin
      bus.err_seq <= (pop && !legal) || (bus.err_seq && !bus.err_clr);
      if (pop && legal) begin
        if (head_cmd == k_START_CMD)     bus_held <= 1'b1;
        else if (head_cmd == k_STOP_CMD) bus_held <= 1'b0;
      end
    end
  end
`else
  assign legal = 1'b1;
`endif

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_cmd[tail]  <= bus.in_cmd;
      mem_data[tail] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      ctr             <= '0;
      bus.cmd_out     <= k_STOP_CMD;
      bus.din_out     <= '0;
      bus.write_out   <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      bus.write_out   <= 1'b0;
      bus.err_timeout <= timeout_hit || (bus.err_timeout && !bus.err_clr);
      case (state)
        IDLE: begin
          if ((count != '0) && bus.ready_in) begin
            state <= ISSUE;
            // An illegal head is still popped in ISSUE, but never strobed
            if (legal) begin
              bus.write_out <= 1'b1;
              bus.cmd_out   <= head_cmd;
              bus.din_out   <= head_data;
            end
          end
        end
        ISSUE: begin
          ctr   <= '0;
          state <= legal ? WAIT_ACK : IDLE;
        end
        WAIT_ACK: begin
          if (ctr != 16'hFFFF) ctr <= ctr + 16'd1;
          if (!bus.ready_in)   state <= WAIT_DONE;
          else if (timeout_hit) state <= IDLE;
        end
        WAIT_DONE: begin
          if (bus.ready_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Directed bench for i2c_cmd_queue with a scoreboard of queued commands checked on each strobe.
// Define I2C_CMDQ_SEQ_CHECK_EN to also exercise the sequence checker.
module tb_i2c_cmd_queue;

  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] WRITE   = 3'd2;
  localparam logic [2:0] READ    = 3'd3;
  localparam logic [2:0] STOP    = 3'd4;
  localparam logic [2:0] RESTART = 3'd5;

  typedef struct packed {
    logic [2:0] cmd;
    logic [7:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  i2c_cmd_queue_if #(.AW(3)) bus();

  i2c_cmd_queue #(.DEPTH(8), .AW(3), .TIMEOUT(16'd1023)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  ent_t exp_q[$];
  int   npass = 0;
  int   nfail = 0;
  int   ntotal = 0;
  int   nstrobe = 0;
  int   n0;
  int   cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    ntotal++;
    nfail++;
    $error("FAIL %s: got no response, expected one", tag);
  endtask

  // One clock: record accepted pushes, then score any strobe against the queue.
  task automatic step();
    logic acc;
    ent_t e;
    acc = bus.in_valid && bus.in_ready && reset_n;
    e   = {bus.in_cmd, bus.in_data};
    @(posedge clk);
    #1;
    if (acc) begin
      exp_q.push_back(e);
      bus.in_valid = 1'b0;
    end
    if (bus.write_out === 1'b1) begin
      nstrobe++;
      if (exp_q.size() == 0) fail_now("strobe_unexpected");
      else begin
        e = exp_q.pop_front();
        chk("strobe_cmd", 32'(bus.cmd_out), 32'(e.cmd));
        if (e.cmd == WRITE) chk("strobe_din", 32'(bus.din_out), 32'(e.data));
      end
    end
  endtask

  task automatic push(input logic [2:0] c, input logic [7:0] d);
    bus.in_cmd   = c;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && bus.in_valid; i++) step();
    if (bus.in_valid) begin
      fail_now("push_timeout");
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_strobe(input int maxc);
    int s0;
    s0 = nstrobe;
    for (int i = 0; i < maxc && nstrobe == s0; i++) step();
    if (nstrobe == s0) fail_now("strobe_timeout");
  endtask

  // Master accepts: ready stays high one cycle, drops for 4, then returns.
  task automatic finish_ack();
    step();
    bus.ready_in = 1'b0;
    repeat (4) step();
    bus.ready_in = 1'b1;
  endtask

  task automatic serve(input int n);
    repeat (n) begin
      wait_strobe(20);
      finish_ack();
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && bus.busy !== 1'b0; i++) step();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_cmd   = '0;
    bus.in_data  = '0;
    bus.ready_in = 1'b0;
    bus.err_clr  = 1'b0;
    repeat (3) step();
    chk("rst_level",    32'(bus.level), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_cmd_out",  32'(bus.cmd_out), 32'(STOP));
    chk("rst_din_out",  32'(bus.din_out), 0);
    chk("rst_write",    32'(bus.write_out), 0);
    chk("rst_busy",     32'(bus.busy), 0);
    chk("rst_err_to",   32'(bus.err_timeout), 0);
`ifdef I2C_CMDQ_SEQ_CHECK_EN
    chk("rst_err_seq",  32'(bus.err_seq), 0);
`endif
    reset_n = 1'b1;
    step();

    // Single START: one-cycle strobe, level 1 -> 0
    bus.ready_in = 1'b1;
    push(START, 8'h00);
    chk("t1_level_after_push", 32'(bus.level), 1);
    n0 = nstrobe;
    step();
    chk("t1_strobe_latency", 32'(nstrobe - n0), 1);
    chk("t1_level_at_issue", 32'(bus.level), 1);
    step();
    chk("t1_strobe_one_cycle", 32'(bus.write_out), 0);
    chk("t1_level_after_pop",  32'(bus.level), 0);
    bus.ready_in = 1'b0;
    repeat (4) step();
    bus.ready_in = 1'b1;
    wait_idle();
    chk("t1_idle", 32'(bus.busy), 0);
    push(STOP, 8'h00);
    serve(1);
    wait_idle();

    // START, WRITE A5, STOP in order
    bus.ready_in = 1'b0;
    push(START, 8'h00);
    push(WRITE, 8'hA5);
    push(STOP,  8'h00);
    n0 = nstrobe;
    bus.ready_in = 1'b1;
    serve(3);
    wait_idle();
    chk("t3_strobes",  32'(nstrobe - n0), 3);
    chk("t3_drained",  32'(exp_q.size()), 0);

    // Fill to DEPTH; a held 9th entry enters after the first pop and issues last
    bus.ready_in = 1'b0;
    push(START, 8'h01);
    push(WRITE, 8'h02);
    push(WRITE, 8'h03);
    push(WRITE, 8'h04);
    push(READ,  8'h05);
    push(READ,  8'h06);
    push(WRITE, 8'h07);
    push(RESTART, 8'h08);
    chk("t4_full_in_ready", 32'(bus.in_ready), 0);
    chk("t4_full_level",    32'(bus.level), 8);
    bus.in_cmd   = STOP;
    bus.in_data  = 8'h09;
    bus.in_valid = 1'b1;
    step();
    chk("t4_full_no_accept", 32'(bus.level), 8);
    n0 = nstrobe;
    bus.ready_in = 1'b1;
    serve(9);
    wait_idle();
    chk("t4_strobes",  32'(nstrobe - n0), 9);
    chk("t4_last_cmd", 32'(bus.cmd_out), 32'(STOP));
    chk("t4_drained",  32'(exp_q.size()), 0);

    // Push in the same cycle as a pop leaves the level unchanged
    bus.ready_in = 1'b0;
    push(START, 8'h00);
    push(WRITE, 8'h3C);
    chk("t5_level2", 32'(bus.level), 2);
    bus.ready_in = 1'b1;
    wait_strobe(5);
    bus.in_cmd   = STOP;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b1;
    step();
    chk("t5_pushpop_level", 32'(bus.level), 2);
    bus.ready_in = 1'b0;
    repeat (4) step();
    bus.ready_in = 1'b1;
    serve(2);
    wait_idle();
    chk("t5_drained", 32'(exp_q.size()), 0);

    // Timeout: ready_in never drops after the strobe
    bus.ready_in = 1'b0;
    push(START, 8'h00);
    push(STOP,  8'h00);
    bus.ready_in = 1'b1;
    wait_strobe(5);
    cycles = 0;
    while (bus.err_timeout !== 1'b1 && cycles < 1100) begin
      step();
      cycles++;
    end
    chk("t6_timeout_cycles", 32'(cycles), 1024);
    chk("t6_err_timeout",    32'(bus.err_timeout), 1);
    chk("t6_idle_after_to",  32'(bus.busy), 0);
    n0 = nstrobe;
    wait_strobe(3);
    chk("t6_next_issued", 32'(nstrobe - n0), 1);
    finish_ack();
    wait_idle();
    chk("t6_err_sticky", 32'(bus.err_timeout), 1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("t6_err_cleared", 32'(bus.err_timeout), 0);

    // Reset in WAIT_DONE with three entries queued
    bus.ready_in = 1'b0;
    push(START, 8'h00);
    push(WRITE, 8'h11);
    push(WRITE, 8'h22);
    push(STOP,  8'h00);
    bus.ready_in = 1'b1;
    wait_strobe(5);
    step();
    bus.ready_in = 1'b0;
    step();
    chk("t7_level_before", 32'(bus.level), 3);
    chk("t7_busy_before",  32'(bus.busy), 1);
    reset_n = 1'b0;
    step();
    chk("t7_level_reset",  32'(bus.level), 0);
    chk("t7_busy_reset",   32'(bus.busy), 0);
    chk("t7_write_reset",  32'(bus.write_out), 0);
    chk("t7_ready_reset",  32'(bus.in_ready), 1);
    exp_q.delete();
    reset_n = 1'b1;
    bus.ready_in = 1'b1;
    n0 = nstrobe;
    repeat (5) step();
    chk("t7_no_issue_after_reset", 32'(nstrobe - n0), 0);

`ifdef I2C_CMDQ_SEQ_CHECK_EN
    // WRITE without a held bus is discarded silently and flags err_seq
    n0 = nstrobe;
    push(WRITE, 8'h55);
    void'(exp_q.pop_back());
    repeat (4) step();
    chk("t8_no_strobe",  32'(nstrobe - n0), 0);
    chk("t8_err_seq",    32'(bus.err_seq), 1);
    chk("t8_level",      32'(bus.level), 0);
    chk("t8_idle",       32'(bus.busy), 0);
    bus.ready_in = 1'b0;
    push(START, 8'h00);
    push(START, 8'h00);
    void'(exp_q.pop_back());
    n0 = nstrobe;
    bus.ready_in = 1'b1;
    serve(1);
    repeat (6) step();
    chk("t8_one_strobe",   32'(nstrobe - n0), 1);
    chk("t8_err_seq_held", 32'(bus.err_seq), 1);
    chk("t8_level_end",    32'(bus.level), 0);
    chk("t8_idle_end",     32'(bus.busy), 0);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("t8_err_seq_clr", 32'(bus.err_seq), 0);
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
